// File: rtl/complex_result_collector.sv
// Purpose : captures a run of complex ALU results into a buffer, then replays them in order on request.
// Latency : capture takes effect on the strobe edge; a read returns data one cycle after rd_req.
// Backpressure: none on capture (one result per cycle); reads are demand-paced by rd_req.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   start, len          arm a run in IDLE; len of 0 or above DEPTH means DEPTH
//   in_valid/in_re/in_im ALU result strobe and payload
//   rd_req              request the next buffered result (READY only)
//   busy, done, count   run status: collecting, buffer full, results captured
//   rd_valid/rd_re/rd_im/rd_last  registered read response; rd_last marks the final entry
//   ovf                 sticky flag for results dropped outside COLLECT
//
// Optional feature: define COLLECTOR_OVF_EN to build the dropped-result detector.
// Without it ovf is tied low. DEPTH must be a power of two and at least 2.

module complex_result_collector #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CW-1:0]     len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              rd_req,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     count,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_re,
    output logic [DATA_W-1:0] rd_im,
    output logic              rd_last,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    // rd_ptr counts reads issued in this run; its low bits address the buffer.
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_re_q, rd_im_q;

    logic              wr_en;
    logic              rd_en;
    logic              start_ok;
    logic [CW-1:0]     len_eff;

    // Buffer carries no reset: contents of an abandoned run are never read.
    logic [2*DATA_W-1:0] mem [DEPTH];

    assign start_ok = (state_q == IDLE) && start;
    assign len_eff  = ((len == '0) || (len > CW'(DEPTH))) ? CW'(DEPTH) : len;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // A strobe coinciding with start is not captured: capture
                // only happens in COLLECT, which begins on the next edge.
                if (start) begin
                    len_d    = len_eff;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    if ((count_q + 1'b1) == len_q) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (rd_req) begin
                    rd_en      = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    // Final read: leave READY on the edge that presents it,
                    // so any further rd_req lands in IDLE and is ignored.
                    if (rd_ptr_q == (len_q - 1'b1)) begin
                        rd_last_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {in_re, in_im};
        end
    end

    // Read data holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_re_q <= '0;
            rd_im_q <= '0;
        end else if (rd_en) begin
            {rd_re_q, rd_im_q} <= mem[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef COLLECTOR_OVF_EN
    logic drop;
    logic ovf_q;

    // Any strobe outside COLLECT is lost; an honoured start takes priority
    // over a same-cycle drop so every new run begins with a clean flag.
    assign drop = in_valid && (state_q != COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign ovf = 1'b0;
`endif

    assign busy     = (state_q == COLLECT);
    assign done     = (state_q == READY);
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_re    = rd_re_q;
    assign rd_im    = rd_im_q;

endmodule

// File: tb/tb_complex_result_collector.sv
// Purpose : directed scoreboard bench for complex_result_collector.
// Latency : expects rd_valid exactly one cycle after each honoured rd_req.
// Backpressure: none; stimulus pushes expected reads, an independent monitor pops them.

module tb_complex_result_collector;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

`ifdef COLLECTOR_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CW-1:0]     len;
    logic              in_valid;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              rd_req;
    logic              busy;
    logic              done;
    logic [CW-1:0]     count;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_re;
    logic [DATA_W-1:0] rd_im;
    logic              rd_last;
    logic              ovf;

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic              last;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    complex_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_re    (in_re),
        .in_im    (in_im),
        .rd_req   (rd_req),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .rd_valid (rd_valid),
        .rd_re    (rd_re),
        .rd_im    (rd_im),
        .rd_last  (rd_last),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every rd_valid must match the oldest expected read, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rd_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rd_valid actual re=%0h im=%0h required no read", rd_re, rd_im);
                end else begin
                    e = sb.pop_front();
                    if (rd_re !== e.re || rd_im !== e.im || rd_last !== e.last || cyc != e.due) begin
                        failures++;
                        $display("FAIL read actual re=%0h im=%0h last=%0b cyc=%0d required re=%0h im=%0h last=%0b cyc=%0d",
                                 rd_re, rd_im, rd_last, cyc, e.re, e.im, e.last, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_rd_valid actual none required re=%0h im=%0h at cyc=%0d", e.re, e.im, e.due);
            end
        end
    end

    // Drive one cycle of inputs, apply them on the next edge, then return to idle inputs.
    task automatic step(input logic st, input logic [CW-1:0] ln, input logic iv,
                        input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im, input logic rq);
        start    = st;
        len      = ln;
        in_valid = iv;
        in_re    = re;
        in_im    = im;
        rd_req   = rq;
        @(posedge clk);
        #1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        rd_req   = 1'b0;
    endtask

    task automatic cap(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        step(1'b0, '0, 1'b1, re, im, 1'b0);
    endtask

    task automatic rd(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im, input logic last);
        exp_t e;
        e.re   = re;
        e.im   = im;
        e.last = last;
        e.due  = cyc + 1;
        sb.push_back(e);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_re = '0; in_im = '0; rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, rd_valid, rd_last, ovf}, 5'b0);
        chk("reset_count", 32'(count), 0);
        chk("reset_rd_data", {rd_re, rd_im}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic four-entry run with signed data.
        step(1'b1, 5'd4, 1'b0, '0, '0, 1'b0);
        chk("t1_busy", busy, 1);
        cap(16'd1, 16'd2);
        cap(16'd3, 16'd4);
        cap(-16'sd5, 16'd6);
        cap(16'd7, -16'sd8);
        chk("t1_ready", {busy, done}, 2'b01);
        chk("t1_count", 32'(count), 4);
        rd(16'd1, 16'd2, 1'b0);
        rd(16'd3, 16'd4, 1'b0);
        rd(-16'sd5, 16'd6, 1'b0);
        rd(16'd7, -16'sd8, 1'b1);
        chk("t1_idle_after_last", {busy, done}, 2'b00);
        idle(2);
        chk("t1_rd_hold", {rd_re, rd_im}, {16'd7, 16'hFFF8});
        chk("t1_count_hold", 32'(count), 4);

        // Reads outside READY and a start inside COLLECT are ignored.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 5'd3, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 16'd10, 16'd11, 1'b1);
        step(1'b1, 5'd1, 1'b1, 16'd12, 16'd13, 1'b0);
        chk("t2_still_collect", {busy, done}, 2'b10);
        chk("t2_count2", 32'(count), 2);
        cap(16'd14, 16'd15);
        chk("t2_ready", {done, 27'(0), count}, {1'b1, 27'(0), 5'd3});
        rd(16'd10, 16'd11, 1'b0);
        rd(16'd12, 16'd13, 1'b0);
        rd(16'd14, 16'd15, 1'b1);
        idle(1);

        // Strobe in the start cycle is not captured.
        step(1'b1, 5'd2, 1'b1, 16'd99, 16'd99, 1'b0);
        chk("t3_count0", 32'(count), 0);
        cap(16'd20, 16'd21);
        cap(16'd22, 16'd23);
        chk("t3_ready", {done, 27'(0), count}, {1'b1, 27'(0), 5'd2});
        rd(16'd20, 16'd21, 1'b0);
        rd(16'd22, 16'd23, 1'b1);
        idle(1);

        // Strobe in READY is dropped and flagged when the detector is built.
        step(1'b1, 5'd2, 1'b0, '0, '0, 1'b0);
        cap(16'd30, 16'd31);
        cap(16'd32, 16'd33);
        cap(16'd9, 16'd9);
        chk("t4_count_unchanged", 32'(count), 2);
        chk("t4_still_ready", done, 1);
        chk("t4_ovf", ovf, OVF_EXP);
        rd(16'd30, 16'd31, 1'b0);
        rd(16'd32, 16'd33, 1'b1);
        idle(1);
        chk("t4_ovf_sticky", ovf, OVF_EXP);

        // len=0 means a full-depth run; start clears ovf.
        step(1'b1, 5'd0, 1'b0, '0, '0, 1'b0);
        chk("t5_ovf_cleared", ovf, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cap(16'(i), 16'(100 + i));
            if (i == DEPTH - 2) begin
                chk("t5_not_done_early", {done, 27'(0), count}, {1'b0, 27'(0), 5'd15});
            end
        end
        chk("t5_ready", {done, 27'(0), count}, {1'b1, 27'(0), 5'd16});
        for (int i = 0; i < DEPTH; i++) begin
            rd(16'(i), 16'(100 + i), (i == DEPTH - 1));
        end
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle(2);

        // Asynchronous reset mid-run abandons it immediately.
        step(1'b1, 5'd8, 1'b0, '0, '0, 1'b0);
        cap(16'd40, 16'd41);
        cap(16'd42, 16'd43);
        cap(16'd44, 16'd45);
        chk("t6_before_reset", {busy, 27'(0), count}, {1'b1, 27'(0), 5'd3});
        rst_n = 1'b0;
        #2;
        chk("t6_reset_state", {busy, done, rd_valid, rd_last, ovf}, 5'b0);
        chk("t6_reset_count", 32'(count), 0);
        chk("t6_reset_rd_data", {rd_re, rd_im}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 5'd1, 1'b0, '0, '0, 1'b0);
        cap(16'd5, 16'd5);
        chk("t6_ready", {done, 27'(0), count}, {1'b1, 27'(0), 5'd1});
        rd(16'd5, 16'd5, 1'b1);
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_result_collector.md
COMPLEX_RESULT_COLLECTOR -- requirements
Module: complex_result_collector

Interface
REQ-001 Parameter DATA_W, default 16: width of each real and imaginary component, two's complement.
REQ-002 Parameter DEPTH, default 16: result buffer entries, power of two; CW = log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that arms a collection run; honoured only in IDLE.
REQ-006 len  input  CW  results to collect, sampled with start; 0 or >DEPTH means DEPTH.
REQ-007 in_valid  input  1  ALU result strobe: in_re/in_im valid this cycle.
REQ-008 in_re  input  DATA_W  real part of ALU result.
REQ-009 in_im  input  DATA_W  imaginary part of ALU result.
REQ-010 rd_req  input  1  read request for the next buffered result.
REQ-011 busy  output  1  high in COLLECT.
REQ-012 done  output  1  high in READY.
REQ-013 count  output  CW  results captured in the current run.
REQ-014 rd_valid  output  1  rd_re/rd_im/rd_last valid this cycle.
REQ-015 rd_re  output  DATA_W  real part of the result being read.
REQ-016 rd_im  output  DATA_W  imaginary part of the result being read.
REQ-017 rd_last  output  1  with rd_valid, marks the final result of the run.
REQ-018 ovf  output  1  sticky dropped-result flag (see Configuration).

Function
REQ-019 States SHALL be IDLE, COLLECT, READY; there are no other states.
REQ-020 IDLE + start: latch len, clear count and write/read pointers, enter COLLECT next edge.
REQ-021 An in_valid in the start cycle SHALL NOT be captured; capture begins the cycle after.
REQ-022 COLLECT + in_valid: write {in_re,in_im} at wr_ptr, increment wr_ptr and count, one result per cycle, no backpressure.
REQ-023 When the capture makes count equal the latched len, enter READY on that same edge; busy low, done high the following cycle.
REQ-024 READY + rd_req: registered read; rd_valid SHALL rise exactly one cycle after rd_req with the entry at rd_ptr; rd_ptr increments.
REQ-025 Back-to-back rd_req SHALL yield one rd_valid per cycle, in capture order.
REQ-026 rd_last SHALL accompany the rd_valid of entry len-1; on that edge state returns to IDLE and done falls.
REQ-027 rd_req after the final request issued, or in IDLE/COLLECT, SHALL be ignored; rd_valid low.
REQ-028 start in COLLECT or READY SHALL be ignored.
REQ-029 in_valid in IDLE or READY SHALL be dropped; buffer and count unchanged.
REQ-030 count SHALL hold its final value through READY and until the next honoured start.
REQ-031 rd_re/rd_im hold their last value when rd_valid is low.

Reset
REQ-032 rst_n low SHALL immediately force IDLE; busy, done, rd_valid, rd_last, ovf = 0; count, pointers, rd_re, rd_im = 0.
REQ-033 Reset mid-COLLECT or mid-READY SHALL abandon the run; buffer contents are not preserved and not guaranteed.
REQ-034 First honoured start SHALL be on the first rising edge with rst_n high.

Configuration
REQ-035 Macro COLLECTOR_OVF_EN: when defined, ovf SHALL set on any in_valid dropped per REQ-029 and clear only on reset or an honoured start.
REQ-036 When COLLECTOR_OVF_EN is undefined, ovf SHALL be constant 0 and no detection logic exists; dropping behaviour is unchanged.

Verification
REQ-037 start,len=4; in_valid 4 cycles with (1,2),(3,4),(-5,6),(7,-8) -> done high, count=4; 4 consecutive rd_req -> rd_valid 1 cycle later each, same data in order, rd_last on (7,-8), state IDLE.
REQ-038 start,len=0; 16 results 0..15 on in_re -> done after 16th capture, count=16; reads return 0..15, rd_last on 15.
REQ-039 start with in_valid same cycle, then 2 valids, len=2 -> first-cycle sample not stored; stored results are the 2 later ones.
REQ-040 len=2 run in READY, in_valid with (9,9) -> buffer unchanged; ovf=1 with COLLECTOR_OVF_EN, 0 without; next start clears ovf.
REQ-041 rst_n low after 3 of 8 captures -> all outputs 0, IDLE; new start,len=1 with (5,5) -> read returns (5,5) with rd_last.
REQ-042 rd_req in IDLE and COLLECT, start in COLLECT -> no rd_valid, run and len unaffected.
